// File: rtl/rr_arbiter_4x2_if.sv
// rr_arbiter_4x2_if: request/grant bundle between the requesters and the round-robin arbiter
interface rr_arbiter_4x2_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  modport master (output req, done, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave (input req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter_4x2.sv
// rr_arbiter_4x2: four-way round-robin arbiter with registered one-hot grant, binary index and hold-limit timeout
module rr_arbiter_4x2 #(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  rr_arbiter_4x2_if.slave   bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] LIM = 8'(MAX_HOLD);
  state_t     state, state_d;
  logic [1:0] ptr, ptr_d, win, win_d, pick;
  logic [3:0] rot;
  logic [7:0] hold_cnt, cnt_d;
  logic       timeout_q, timeout_d, go, rel;
  // state register; outputs derive only from these flops so inputs never reach them combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      win       <= 2'd0;
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      win       <= win_d;
      hold_cnt  <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  // next state: rotate requests so ptr sits at bit 0, first set bit wins; release on done, drop or hold limit
  always_comb begin
    rot       = 4'({bus.req, bus.req} >> ptr);
    pick      = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
    go        = state == IDLE && |bus.req;
    rel       = state == GRANT && (bus.done || !bus.req[win] || hold_cnt == LIM);
    state_d   = go ? GRANT : rel ? IDLE : state;
    win_d     = go ? pick : win;
    ptr_d     = rel ? win + 2'd1 : ptr;
    cnt_d     = go ? 8'd1 : rel ? 8'd0 : state == GRANT ? hold_cnt + 8'd1 : hold_cnt;
    timeout_d = rel && !bus.done && bus.req[win];
  end
  // outputs decoded from registered state; IDLE forces everything to zero
  always_comb begin
    bus.gnt_valid = state == GRANT;
    bus.gnt       = bus.gnt_valid ? 4'b0001 << win : 4'b0000;
    bus.gnt_idx   = bus.gnt_valid ? win : 2'd0;
    bus.timeout   = timeout_q;
  end
endmodule

// File: tb/tb_rr_arbiter_4x2.sv
// tb_rr_arbiter_4x2: directed and randomized checking of the round-robin arbiter against a behavioural model
module tb_rr_arbiter_4x2;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   owner, held, mptr;
  bit   mto;
  rr_arbiter_4x2_if bus ();
  rr_arbiter_4x2 #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    held  = 0;
    mptr  = 0;
    mto   = 1'b0;
  endtask

  task automatic model_edge();
    bit lim;
    if (rst) begin
      model_reset();
    end else begin
      mto = 1'b0;
      if (owner < 0) begin
        if (bus.req != 4'b0000)
          for (int k = 0; k < 4; k++)
            if (owner < 0 && bus.req[(mptr + k) % 4]) begin
              owner = (mptr + k) % 4;
              held  = 1;
            end
      end else begin
        lim = held == MH;
        if (bus.done || !bus.req[owner] || lim) begin
          mto   = lim && !bus.done && bus.req[owner];
          mptr  = (owner + 1) % 4;
          owner = -1;
          held  = 0;
        end else begin
          held++;
        end
      end
    end
  endtask

  task automatic compare();
    chk("gnt", int'(bus.gnt), owner < 0 ? 0 : (1 << owner));
    chk("gnt_idx", int'(bus.gnt_idx), owner < 0 ? 0 : owner);
    chk("gnt_valid", int'(bus.gnt_valid), owner < 0 ? 0 : 1);
    chk("timeout", int'(bus.timeout), int'(mto));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.done = 1'b0;
    #1;
    chk("reset_gnt_async", int'(bus.gnt), 0);
    chk("reset_valid_async", int'(bus.gnt_valid), 0);
    chk("reset_idx_async", int'(bus.gnt_idx), 0);
    chk("reset_timeout_async", int'(bus.timeout), 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("first_gnt", int'(bus.gnt), 4'b0001);
    chk("first_idx", int'(bus.gnt_idx), 0);
    for (int i = 1; i <= 4; i++) begin
      bus.done = 1'b1;
      cyc();
      chk("rot_idle", int'(bus.gnt_valid), 0);
      bus.done = 1'b0;
      cyc();
      chk("rot_idx", int'(bus.gnt_idx), i % 4);
    end
    bus.done = 1'b1;
    bus.req = 4'b0100;
    cyc();
    bus.done = 1'b0;
    cyc();
    chk("skip_to_2", int'(bus.gnt_idx), 2);
    bus.done = 1'b1;
    bus.req = 4'b0011;
    cyc();
    bus.done = 1'b0;
    cyc();
    chk("wrap_to_0", int'(bus.gnt), 4'b0001);
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
    cyc();
    chk("wrap_then_1", int'(bus.gnt_idx), 1);
    bus.done = 1'b1;
    cyc();
    bus.done = 1'b0;
    bus.req = 4'b0100;
    for (int i = 0; i < MH; i++) begin
      cyc();
      chk("hold_gnt", int'(bus.gnt), 4'b0100);
      chk("hold_idx", int'(bus.gnt_idx), 2);
    end
    cyc();
    chk("timeout_pulse", int'(bus.timeout), 1);
    chk("timeout_idle", int'(bus.gnt_valid), 0);
    cyc();
    chk("regrant_2", int'(bus.gnt), 4'b0100);
    chk("timeout_once", int'(bus.timeout), 0);
    cyc();
    cyc();
    cyc();
    bus.done = 1'b1;
    cyc();
    chk("done_beats_limit_to", int'(bus.timeout), 0);
    chk("done_beats_limit_v", int'(bus.gnt_valid), 0);
    bus.done = 1'b0;
    cyc();
    chk("regrant_after_done", int'(bus.gnt_idx), 2);
    cyc();
    bus.req = 4'b0000;
    cyc();
    chk("drop_release_v", int'(bus.gnt_valid), 0);
    chk("drop_release_to", int'(bus.timeout), 0);
    bus.req = 4'b1000;
    cyc();
    chk("grant_3", int'(bus.gnt), 4'b1000);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midreset_gnt", int'(bus.gnt), 0);
    chk("midreset_valid", int'(bus.gnt_valid), 0);
    chk("midreset_idx", int'(bus.gnt_idx), 0);
    @(negedge clk);
    bus.req = 4'b1111;
    cyc();
    rst = 1'b0;
    cyc();
    chk("after_reset_ptr0", int'(bus.gnt), 4'b0001);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) bus.req = 4'($urandom_range(15));
      bus.done = $urandom_range(7) == 0;
      rst = $urandom_range(199) == 0;
      cyc();
    end
    rst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
